// File: rtl/cover_hit_collector_pkg.sv
// Shared types and helpers for the cover hit collector.
package cover_pkg;

  // Readout handshake states.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } fsm_e;

  localparam int CNT_W_DEF = 8;
  localparam int TS_W_DEF  = 16;

  // Per-event record at the default widths; modules with other widths
  // declare an equivalent record locally.
  typedef struct packed {
    logic                 hit;
    logic                 sat;
    logic [CNT_W_DEF-1:0] cnt;
    logic [TS_W_DEF-1:0]  first_ts;
  } evt_rec_t;

  // Saturating increment on a 32-bit carrier (counter widths up to 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/cover_hit_collector_evt_slice.sv
// One event's bookkeeping: edge detect, saturating counter, sticky flag
// and first-hit stamp.
module cover_evt_slice
  import cover_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int TS_W      = 16,
  parameter int EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt,
  input  logic             clr,
  input  logic [TS_W-1:0]  ts,
  output logic             hit,
  output logic             sat,
  output logic [CNT_W-1:0] cnt,
  output logic [TS_W-1:0]  first_ts
);

  localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                  : ((32'd1 << CNT_W) - 32'd1);

  logic evt_q;
  logic counted;

  // A sampled event counts either on level or only on its rising edge.
  always_comb begin
    counted = evt;
    if (EDGE_MODE != 0) begin
      counted = evt & ~evt_q;
    end
  end

  assign sat = (32'(cnt) == CNT_MAX);

  // Clear beats same-cycle hits; evt_q keeps tracking so a held level is not re-counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q    <= 1'b0;
      hit      <= 1'b0;
      cnt      <= '0;
      first_ts <= '0;
    end else begin
      evt_q <= evt;
      if (clr) begin
        hit      <= 1'b0;
        cnt      <= '0;
        first_ts <= '0;
      end else if (counted) begin
        cnt <= CNT_W'(sat_inc(32'(cnt), CNT_MAX));
        hit <= 1'b1;
        if (!hit) begin
          first_ts <= ts;
        end
      end
    end
  end

endmodule

// File: rtl/cover_hit_collector.sv
// Cover hit collector: per-event slices, free-running cycle stamp and a
// valid/ready readout port returning one event snapshot per request.
module cover_hit_collector
  import cover_pkg::*;
#(
  parameter int N_EVT     = 8,
  parameter int CNT_W     = 8,
  parameter int TS_W      = 16,
  parameter int EDGE_MODE = 0,
  localparam int IDX_W    = (N_EVT > 1) ? $clog2(N_EVT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_EVT-1:0] evt_i,
  input  logic             clr_i,
  input  logic             rd_valid_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_ready_o,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_hit_o,
  output logic             resp_sat_o,
  output logic [CNT_W-1:0] resp_cnt_o,
  output logic [TS_W-1:0]  resp_ts_o,
  output logic             resp_err_o,
  output logic             all_covered_o,
  output logic [N_EVT-1:0] hit_vec_o
);

  typedef struct packed {
    logic             hit;
    logic             sat;
    logic [CNT_W-1:0] cnt;
    logic [TS_W-1:0]  first_ts;
  } rec_t;

  logic [TS_W-1:0]  ts;
  logic [N_EVT-1:0] hit_w;
  logic [N_EVT-1:0] sat_w;
  logic [CNT_W-1:0] cnt_w [N_EVT];
  logic [TS_W-1:0]  fts_w [N_EVT];

  fsm_e state, state_next;
  logic load;
  logic idx_err;
  rec_t sel_rec;

  // Free-running cycle stamp; reads 0 at the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  for (genvar g = 0; g < N_EVT; g++) begin : g_slice
    cover_evt_slice #(
      .CNT_W     (CNT_W),
      .TS_W      (TS_W),
      .EDGE_MODE (EDGE_MODE)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .evt      (evt_i[g]),
      .clr      (clr_i),
      .ts       (ts),
      .hit      (hit_w[g]),
      .sat      (sat_w[g]),
      .cnt      (cnt_w[g]),
      .first_ts (fts_w[g])
    );
  end

  // Hit flags are already registered in the slices, so these track the counters.
  assign hit_vec_o     = hit_w;
  assign all_covered_o = &hit_w;

  // Select the pre-update state of the requested event; out-of-range reads all-zero.
  always_comb begin
    sel_rec = '0;
    idx_err = (32'(rd_idx_i) >= 32'(N_EVT));
    if (!idx_err) begin
      sel_rec.hit      = hit_w[rd_idx_i];
      sel_rec.sat      = sat_w[rd_idx_i];
      sel_rec.cnt      = cnt_w[rd_idx_i];
      sel_rec.first_ts = fts_w[rd_idx_i];
    end
  end

  // Readout state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake decode: accept in IDLE, hold the response in RESP until consumed.
  always_comb begin
    state_next   = state;
    load         = 1'b0;
    rd_ready_o   = 1'b0;
    resp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        rd_ready_o = 1'b1;
        if (rd_valid_i) begin
          load       = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Latched response; only an accept changes it, live updates never do.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_hit_o <= 1'b0;
      resp_sat_o <= 1'b0;
      resp_cnt_o <= '0;
      resp_ts_o  <= '0;
      resp_err_o <= 1'b0;
    end else if (load) begin
      resp_hit_o <= sel_rec.hit;
      resp_sat_o <= sel_rec.sat;
      resp_cnt_o <= sel_rec.cnt;
      resp_ts_o  <= sel_rec.first_ts;
      resp_err_o <= idx_err;
    end
  end

endmodule

// File: tb/tb_cover_hit_collector.sv
// Scoreboard bench for cover_hit_collector: two instances (level and edge
// counting) share stimulus; a behavioural model predicts responses.
module tb_cover_hit_collector;

  localparam int N    = 6;
  localparam int CW   = 4;
  localparam int TW   = 16;
  localparam int IW   = 3;
  localparam int CMAX = 15;

  typedef struct {
    bit hit;
    bit sat;
    int cnt;
    int ts;
    bit err;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [N-1:0]  evt_i;
  logic          clr_i;
  logic          rd_valid_i;
  logic [IW-1:0] rd_idx_i;
  logic          resp_ready_i;

  logic          rd_ready0, resp_valid0, resp_hit0, resp_sat0, resp_err0, all_cov0;
  logic [CW-1:0] resp_cnt0;
  logic [TW-1:0] resp_ts0;
  logic [N-1:0]  hit_vec0;
  logic          rd_ready1, resp_valid1, resp_hit1, resp_sat1, resp_err1, all_cov1;
  logic [CW-1:0] resp_cnt1;
  logic [TW-1:0] resp_ts1;
  logic [N-1:0]  hit_vec1;

  int   checks = 0;
  int   passes = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   mcnt [2][N];
  bit   mhit [2][N];
  int   mfts [2][N];
  bit   mprev[N];
  int   tsm;
  bit   pending;

  cover_hit_collector #(.N_EVT(N), .CNT_W(CW), .TS_W(TW), .EDGE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .evt_i(evt_i), .clr_i(clr_i),
    .rd_valid_i(rd_valid_i), .rd_idx_i(rd_idx_i), .rd_ready_o(rd_ready0),
    .resp_valid_o(resp_valid0), .resp_ready_i(resp_ready_i),
    .resp_hit_o(resp_hit0), .resp_sat_o(resp_sat0), .resp_cnt_o(resp_cnt0),
    .resp_ts_o(resp_ts0), .resp_err_o(resp_err0),
    .all_covered_o(all_cov0), .hit_vec_o(hit_vec0)
  );

  cover_hit_collector #(.N_EVT(N), .CNT_W(CW), .TS_W(TW), .EDGE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .evt_i(evt_i), .clr_i(clr_i),
    .rd_valid_i(rd_valid_i), .rd_idx_i(rd_idx_i), .rd_ready_o(rd_ready1),
    .resp_valid_o(resp_valid1), .resp_ready_i(resp_ready_i),
    .resp_hit_o(resp_hit1), .resp_sat_o(resp_sat1), .resp_cnt_o(resp_cnt1),
    .resp_ts_o(resp_ts1), .resp_err_o(resp_err1),
    .all_covered_o(all_cov1), .hit_vec_o(hit_vec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t snap(input int m, input int idx);
    exp_t e;
    e = '{hit: 1'b0, sat: 1'b0, cnt: 0, ts: 0, err: 1'b0};
    if (idx >= N) begin
      e.err = 1'b1;
    end else begin
      e.hit = mhit[m][idx];
      e.cnt = mcnt[m][idx];
      e.sat = (mcnt[m][idx] == CMAX);
      e.ts  = mfts[m][idx];
    end
    return e;
  endfunction

  // Reference model: spec rules applied per sampled edge, snapshot taken before update.
  always @(posedge clk or posedge rst) begin
    bit counted;
    if (rst) begin
      q0.delete();
      q1.delete();
      pending = 1'b0;
      tsm = 0;
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < N; i++) begin
          mcnt[m][i] = 0;
          mhit[m][i] = 1'b0;
          mfts[m][i] = 0;
        end
      end
      for (int i = 0; i < N; i++) mprev[i] = 1'b0;
    end else begin
      if (!pending && rd_valid_i) begin
        q0.push_back(snap(0, int'(rd_idx_i)));
        q1.push_back(snap(1, int'(rd_idx_i)));
        pending = 1'b1;
      end else if (pending && resp_ready_i) begin
        pending = 1'b0;
      end
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < N; i++) begin
          counted = (m == 0) ? evt_i[i] : (evt_i[i] && !mprev[i]);
          if (clr_i) begin
            mcnt[m][i] = 0;
            mhit[m][i] = 1'b0;
            mfts[m][i] = 0;
          end else if (counted) begin
            if (mcnt[m][i] < CMAX) mcnt[m][i] = mcnt[m][i] + 1;
            if (!mhit[m][i]) begin
              mhit[m][i] = 1'b1;
              mfts[m][i] = tsm;
            end
          end
        end
      end
      for (int i = 0; i < N; i++) mprev[i] = evt_i[i];
      tsm = (tsm + 1) % (1 << TW);
    end
  end

  task automatic monitorDut(input int m, input logic rdy, input logic vld,
                            input logic hit, input logic sat, input logic [CW-1:0] cnt,
                            input logic [TW-1:0] ts, input logic err,
                            input logic allc, input logic [N-1:0] hv);
    exp_t e;
    logic [N-1:0] ehv;
    bit eall;
    string p;
    p = (m == 0) ? "lvl" : "edge";
    eall = 1'b1;
    for (int i = 0; i < N; i++) begin
      ehv[i] = mhit[m][i];
      if (!mhit[m][i]) eall = 1'b0;
    end
    checkOutput({p, "_hit_vec"}, hv, ehv);
    checkOutput({p, "_all_covered"}, allc, eall);
    checkOutput({p, "_resp_valid"}, vld, pending);
    checkOutput({p, "_rd_ready"}, rdy, !pending);
    if (vld) begin
      if ((m == 0 ? q0.size() : q1.size()) == 0) begin
        checkOutput({p, "_resp_unexpected"}, vld, 0);
      end else begin
        e = (m == 0) ? q0[0] : q1[0];
        checkOutput({p, "_resp_hit"}, hit, e.hit);
        checkOutput({p, "_resp_sat"}, sat, e.sat);
        checkOutput({p, "_resp_cnt"}, cnt, e.cnt);
        checkOutput({p, "_resp_ts"}, ts, e.ts);
        checkOutput({p, "_resp_err"}, err, e.err);
        if (resp_ready_i) begin
          if (m == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
        end
      end
    end
  endtask

  // Monitor samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      monitorDut(0, rd_ready0, resp_valid0, resp_hit0, resp_sat0, resp_cnt0,
                 resp_ts0, resp_err0, all_cov0, hit_vec0);
      monitorDut(1, rd_ready1, resp_valid1, resp_hit1, resp_sat1, resp_cnt1,
                 resp_ts1, resp_err1, all_cov1, hit_vec1);
    end
  end

  task automatic applyStimulus(input logic [N-1:0] e, input logic c, input logic rv,
                               input logic [IW-1:0] ix, input logic rr);
    evt_i        = e;
    clr_i        = c;
    rd_valid_i   = rv;
    rd_idx_i     = ix;
    resp_ready_i = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    evt_i = '0;
    clr_i = 1'b0;
    rd_valid_i = 1'b0;
    rd_idx_i = '0;
    resp_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rd_ready", rd_ready0, 1);
    checkOutput("reset_hit_vec", hit_vec0, 0);
    rst = 1'b0;

    // Level counting: event 0 at stamps 10..12.
    repeat (10) applyStimulus('0, 0, 0, 0, 0);
    repeat (3) applyStimulus(6'b000001, 0, 0, 0, 0);
    applyStimulus('0, 0, 1, 3'd0, 0);
    checkOutput("t2_cnt", resp_cnt0, 3);
    checkOutput("t2_ts", resp_ts0, 10);
    checkOutput("t2_hit", resp_hit0, 1);
    checkOutput("t2_edge_cnt", resp_cnt1, 1);
    applyStimulus('0, 0, 0, 0, 1);

    // Saturation on event 3, then cover every event.
    repeat (20) applyStimulus(6'b001000, 0, 0, 0, 0);
    applyStimulus('0, 0, 1, 3'd3, 0);
    checkOutput("t3_cnt", resp_cnt0, 15);
    checkOutput("t3_sat", resp_sat0, 1);
    applyStimulus('0, 0, 0, 0, 1);
    checkOutput("t3_not_covered", all_cov0, 0);
    applyStimulus(6'b111111, 0, 0, 0, 0);
    checkOutput("t3_covered", all_cov0, 1);
    checkOutput("t3_edge_covered", all_cov1, 1);

    // Edge counting on event 2 after a clear.
    applyStimulus('0, 1, 0, 0, 0);
    applyStimulus(6'b000100, 0, 0, 0, 0);
    applyStimulus(6'b000100, 0, 0, 0, 0);
    applyStimulus(6'b000100, 0, 0, 0, 0);
    applyStimulus('0, 0, 0, 0, 0);
    applyStimulus(6'b000100, 0, 0, 0, 0);
    applyStimulus('0, 0, 1, 3'd2, 0);
    checkOutput("t4_edge_cnt", resp_cnt1, 2);
    checkOutput("t4_lvl_cnt", resp_cnt0, 4);
    applyStimulus('0, 0, 0, 0, 1);

    // Clear wins over a same-cycle hit.
    applyStimulus(6'b000010, 1, 0, 0, 0);
    applyStimulus('0, 0, 0, 0, 0);
    checkOutput("t5_hit_vec1", hit_vec0[1], 0);
    applyStimulus(6'b000010, 0, 0, 0, 0);
    applyStimulus('0, 0, 1, 3'd1, 0);
    checkOutput("t5_cnt", resp_cnt0, 1);
    applyStimulus('0, 0, 0, 0, 1);

    // Stalled response ignores live hits; out-of-range index.
    applyStimulus('0, 0, 1, 3'd1, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(6'b000010, 0, 1, 3'd0, 0);
      checkOutput("t6_rd_ready", rd_ready0, 0);
      checkOutput("t6_cnt_held", resp_cnt0, 1);
    end
    applyStimulus('0, 0, 0, 0, 1);
    applyStimulus('0, 0, 1, 3'd6, 0);
    checkOutput("t6_err", resp_err0, 1);
    checkOutput("t6_err_cnt", resp_cnt0, 0);
    applyStimulus('0, 0, 0, 0, 1);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(N'($urandom) & N'($urandom), ($urandom_range(19) == 0),
                    $urandom_range(1), IW'($urandom_range(7)), $urandom_range(1));
    end

    // Reset while a response is pending.
    applyStimulus(6'b111111, 0, 0, 0, 1);
    applyStimulus('0, 0, 1, 3'd4, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t1_resp_valid", resp_valid0, 0);
    checkOutput("t1_rd_ready", rd_ready0, 1);
    checkOutput("t1_hit_vec", hit_vec0, 0);
    checkOutput("t1_all_covered", all_cov0, 0);
    checkOutput("t1_edge_resp_valid", resp_valid1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) applyStimulus('0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cover_hit_collector.md
Name: cover_hit_collector

Overview:
Synthesizable receiving end for cover events. Design-side monitors drive single-bit event strobes, sampled on the rising edge of clk. Per event, the block keeps a saturating hit count, a sticky hit flag and the cycle stamp of the first hit. A bench or debug master reads these back one event at a time over a valid/ready request and response interface. It is the hardware counterpart of simulator cover-property reporting and is used in emulation and in tests that must self-check coverage.

Parameters:
N_EVT, 8, number of event inputs (1..32)
CNT_W, 8, hit counter width; counters saturate at 2^CNT_W-1
TS_W, 16, width of the free-running cycle stamp; wraps modulo 2^TS_W
EDGE_MODE, 0, 0 = count every cycle the event is high; 1 = count only rising edges of the event

Ports:
clk  in  1  single clock; all state is updated on posedge clk
rst  in  1  reset, asynchronous, active-high
evt_i  in  N_EVT  event strobes, sampled each posedge clk
clr_i  in  1  synchronous clear of all per-event state
rd_valid_i  in  1  readout request valid
rd_idx_i  in  $clog2(N_EVT) (min 1)  index of the event to read
rd_ready_o  out  1  request accepted when rd_valid_i and rd_ready_o are both high
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response consumed when resp_valid_o and resp_ready_i are both high
resp_hit_o  out  1  sticky hit flag of the selected event
resp_sat_o  out  1  selected counter is saturated
resp_cnt_o  out  CNT_W  hit count
resp_ts_o  out  TS_W  cycle stamp of the first hit
resp_err_o  out  1  rd_idx_i was >= N_EVT
all_covered_o  out  1  AND of all hit flags
hit_vec_o  out  N_EVT  live sticky hit flags

Behaviour:
- Reset state (rst=1, asynchronous): all counters, flags, stamps, the cycle counter, the previous-event register and all resp_* outputs are 0. all_covered_o=0, hit_vec_o=0. FSM is IDLE, so rd_ready_o=1.
- Cycle counter ts:
  - 0 on the first posedge after reset deassertion; increments by 1 on every posedge after that; wraps modulo 2^TS_W.
  - clr_i does not affect ts.
- Counted hit for event i in a cycle:
  - EDGE_MODE=0: evt_i[i]=1.
  - EDGE_MODE=1: evt_i[i]=1 and evt_q[i]=0, where evt_q is evt_i registered one cycle (reset value 0). A high level held through reset release counts once.
- On a counted hit:
  - cnt increments by 1, or holds if already at 2^CNT_W-1 (sat then reads 1).
  - hit is set.
  - If hit was 0 before this edge, first_ts captures the current ts. Later hits never change first_ts.
- hit_vec_o and all_covered_o are registered and reflect state updated at the same edge as the counters (one cycle after the event is sampled).
- clr_i=1 at a posedge: every cnt, hit and first_ts goes to 0.
  - Clear wins over hits sampled in the same cycle; those hits are dropped.
  - evt_q still updates, so a level still high after clr_i deasserts does not count as a new edge in EDGE_MODE=1.
- FSM has two states, IDLE and RESP.
  - IDLE: rd_ready_o=1. On rd_valid_i and rd_ready_o, latch a snapshot of event rd_idx_i into the resp_* registers and go to RESP.
    - The snapshot is the state before this edge's update, so a hit in the accept cycle is not included.
    - If rd_idx_i >= N_EVT: resp_err_o=1 and all data fields are 0.
  - RESP: resp_valid_o=1, rd_ready_o=0. resp_* stay stable until resp_ready_i=1, then go to IDLE next edge with resp_valid_o=0.
  - Back-to-back throughput is one request per 2 cycles. Latency is 1 cycle from accept to resp_valid_o.
- Interaction with RESP: clr_i and new hits during RESP update the live state only, never the latched response.
- Reset mid-transaction: outputs return to reset values immediately and any pending response is discarded.
- resp_* data are don't-care when resp_valid_o=0; the implementation holds the last value.

Decomposition:
- Package cover_pkg holds:
  - fsm_e {IDLE, RESP}
  - struct evt_rec_t {hit, sat, cnt, first_ts}, parameterized through package localparams defaults CNT_W/TS_W or via typedef in module
  - function sat_inc()
- One sub-module, cover_evt_slice, is natural: per-event counter, sticky flag, first_ts capture and edge detect, instantiated N_EVT times with a generate loop.
- The top level holds ts, the FSM and the readout mux.

Test Plan:
1. Reset: assert rst mid-simulation with a response pending -> resp_valid_o=0, rd_ready_o=1, hit_vec_o=0, all_covered_o=0 in the same time step.
2. EDGE_MODE=0: evt_i[0] high at ts=10,11,12, then read idx 0 -> resp_cnt_o=3, resp_ts_o=10, resp_hit_o=1, resp_sat_o=0, resp_err_o=0.
3. CNT_W=4: evt_i[3] held high 20 cycles, then read -> resp_cnt_o=15, resp_sat_o=1. Drive all events once -> all_covered_o=1 one cycle after the last one.
4. EDGE_MODE=1: evt_i[2] pulses 0-1-1-1-0-1 -> resp_cnt_o=2, resp_ts_o = stamp of the first rise.
5. clr_i and evt_i[1] in the same cycle -> cnt stays 0, hit_vec_o[1]=0. Next isolated pulse -> cnt=1 with the new stamp.
6. Readout: hold resp_ready_i=0 for 5 cycles -> resp_* stable, rd_ready_o=0, and a hit during the wait is not reflected. Read idx=N_EVT -> resp_err_o=1, resp_cnt_o=0.
